// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / duty-measurement pair.
package pwm_pkg;

    localparam int PWM_WIDTH  = 11;
    localparam int PWM_PERIOD = 2 ** PWM_WIDTH;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, plus one delay flop
// giving single-cycle rise/fall strobes on the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_sig,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_duty_meas.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// reporting once per period, and flags an input that stops toggling.
//
// state     | meaning
// WAIT_RISE | counters idle, waiting for first rise (after reset or stuck)
// HIGH      | counting clks while synchronized input is high
// LOW       | counting clks while low; next rise publishes the measurement
module pwm_duty_meas
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty_out,
    output logic [WIDTH:0]   period_out,
    output logic             meas_vld,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic s, rise, fall, any_edge, stuck_hit, report;

    meas_state_t      state, state_nxt;
    logic [WIDTH-1:0] hi_cnt, hi_nxt;
    logic [WIDTH:0]   lo_cnt, lo_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WIDTH+1:0] sum_full;
    logic [WIDTH:0]   period_sat;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_sig (pwm_in),
        .s         (s),
        .rise      (rise),
        .fall      (fall)
    );

    assign any_edge  = rise | fall;
    // an edge in the same cycle resets the idle count, so it wins over timeout
    assign stuck_hit = ~any_edge && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    assign sum_full   = {2'b00, hi_cnt} + {1'b0, lo_cnt};
    assign period_sat = sum_full[WIDTH+1] ? '1 : sum_full[WIDTH:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= WAIT_RISE;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            state  <= state_nxt;
            hi_cnt <= hi_nxt;
            lo_cnt <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        lo_nxt    = lo_cnt;
        report    = 1'b0;
        if (stuck_hit) begin
            state_nxt = WAIT_RISE;
            hi_nxt    = '0;
            lo_nxt    = '0;
        end else begin
            case (state)
                WAIT_RISE: begin
                    hi_nxt = '0;
                    lo_nxt = '0;
                    if (rise) begin
                        hi_nxt    = WIDTH'(1);
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lo_nxt    = (WIDTH+1)'(1);
                        state_nxt = LOW;
                    end else if (s && (hi_cnt != '1)) begin
                        hi_nxt = hi_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        report    = 1'b1;
                        hi_nxt    = WIDTH'(1);
                        lo_nxt    = '0;
                        state_nxt = HIGH;
                    end else if (!s && (lo_cnt != '1)) begin
                        lo_nxt = lo_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = WAIT_RISE;
                    hi_nxt    = '0;
                    lo_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (any_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_out   <= '0;
            period_out <= '0;
            meas_vld   <= 1'b0;
            stuck      <= 1'b0;
            stuck_lvl  <= 1'b0;
        end else begin
            meas_vld <= 1'b0;
            if (stuck_hit) begin
                stuck      <= 1'b1;
                stuck_lvl  <= s;
                duty_out   <= s ? '1 : '0;
                period_out <= '0;
                meas_vld   <= 1'b1;
            end else begin
                if (report) begin
                    duty_out   <= hi_cnt;
                    period_out <= period_sat;
                    meas_vld   <= 1'b1;
                end
                if (any_edge) begin
                    stuck     <= 1'b0;
                    stuck_lvl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Bench for pwm_duty_meas: run-length model of the sampled input checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pwm_duty_meas;

    localparam int W    = 11;
    localparam int NS   = 2;
    localparam int TO   = 4096;
    localparam int DMAX = 2047;
    localparam int PMAX = 4095;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [W-1:0]  duty_out;
    logic [W:0]    period_out;
    logic          meas_vld, stuck, stuck_lvl;

    pwm_duty_meas #(.WIDTH(W), .SYNC_STAGES(NS), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .meas_vld   (meas_vld),
        .stuck      (stuck),
        .stuck_lvl  (stuck_lvl)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0, pass_cnt = 0, cyc = 0;

    // model: run lengths of the input as seen NS clks later
    int m_q[$];
    int m_prev, m_idle, m_hi, m_lo;
    bit m_armed, m_sawfall;
    int e_duty, e_period;
    bit e_vld, e_stuck, e_lvl;

    int x_prev_raw = 0, last_fall_cyc = 0, stuck_cyc = 0;
    bit stuck_d = 1'b0;
    int last_duty = 0, last_period = 0, vld_count = 0, last_vld_cyc = 0, vld_gap = 0;
    int jit_nom = 0, jit_reports = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function void model_reset();
        m_q = {};
        for (int i = 0; i < NS; i++) m_q.push_back(0);
        m_prev = 0; m_idle = 0; m_hi = 0; m_lo = 0;
        m_armed = 0; m_sawfall = 0;
        e_duty = 0; e_period = 0; e_vld = 0; e_stuck = 0; e_lvl = 0;
    endfunction

    function void model_step(int x);
        int y;
        m_q.push_back(x);
        y = m_q.pop_front();
        e_vld = 0;
        if (y != m_prev) begin
            e_stuck = 0;
            e_lvl   = 0;
            m_idle  = 0;
            if (y == 1) begin
                if (m_armed && m_sawfall) begin
                    e_duty   = imin(m_hi, DMAX);
                    e_period = imin(imin(m_hi, DMAX) + imin(m_lo, PMAX), PMAX);
                    e_vld    = 1;
                end
                m_armed = 1; m_sawfall = 0; m_hi = 1; m_lo = 0;
            end else if (m_armed) begin
                m_sawfall = 1;
                m_lo      = 1;
            end
        end else if (m_idle == TO - 1) begin
            m_idle   = TO;
            e_stuck  = 1;
            e_lvl    = y[0];
            e_duty   = (y == 1) ? DMAX : 0;
            e_period = 0;
            e_vld    = 1;
            m_armed  = 0; m_sawfall = 0; m_hi = 0; m_lo = 0;
        end else begin
            if (m_idle < TO) m_idle++;
            if (m_armed && y == 1 && !m_sawfall) m_hi++;
            if (m_armed && y == 0 && m_sawfall) m_lo++;
        end
        m_prev = y;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        int x;
        if (rst) begin
            model_reset();
        end else begin
            cyc++;
            x = int'(pwm_in);
            if (x_prev_raw == 1 && x == 0) last_fall_cyc = cyc;
            x_prev_raw = x;
            model_step(x);
            #1;
            chk_cnt++;
            if ($isunknown({duty_out, period_out, meas_vld, stuck, stuck_lvl}) ||
                int'(duty_out) != e_duty || int'(period_out) != e_period ||
                meas_vld != e_vld || stuck != e_stuck || stuck_lvl != e_lvl)
                $display("FAIL cycle %0d: got duty=%0d period=%0d vld=%b stuck=%b lvl=%b expected duty=%0d period=%0d vld=%b stuck=%b lvl=%b",
                         cyc, duty_out, period_out, meas_vld, stuck, stuck_lvl,
                         e_duty, e_period, e_vld, e_stuck, e_lvl);
            else
                pass_cnt++;
            if (meas_vld) begin
                vld_count++;
                vld_gap      = cyc - last_vld_cyc;
                last_vld_cyc = cyc;
                last_duty    = int'(duty_out);
                last_period  = int'(period_out);
                if (jit_nom != 0) begin
                    jit_reports++;
                    check("jitter_period_pm1",
                          (last_period >= jit_nom - 1 && last_period <= jit_nom + 1) ? 1 : 0, 1);
                end
            end
            if (stuck && !stuck_d) stuck_cyc = cyc;
            stuck_d = stuck;
        end
    end

    task automatic drive(input int lvl, input int n);
        pwm_in = lvl[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic gen(input int d, input int n);
        repeat (n) begin
            if (d > 0)    drive(1, d);
            if (d < 2048) drive(0, 2048 - d);
        end
    endtask

    task automatic wait_until(input longint t);
        longint now;
        now = longint'($time);
        if (t > now) #(t - now);
    endtask

    function automatic int jit();
        return int'($urandom_range(0, 6)) - 3;
    endfunction

    initial begin
        int v0, h, l, p;
        longint t0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_duty", int'(duty_out), 0);
        check("reset_period", int'(period_out), 0);
        check("reset_vld", int'(meas_vld), 0);
        check("reset_stuck", int'(stuck), 0);
        check("reset_lvl", int'(stuck_lvl), 0);
        rst = 1'b0;

        gen(512, 3);
        check("d200_count", vld_count, 2);
        check("d200_duty", last_duty, 512);
        check("d200_period", last_period, 2048);
        check("d200_gap", vld_gap, 2048);
        check("d200_stuck", int'(stuck), 0);

        gen(2047, 2);
        check("d7ff_duty", last_duty, 2047);
        check("d7ff_period", last_period, 2048);
        gen(1, 2);
        check("d001_duty", last_duty, 1);
        check("d001_period", last_period, 2048);

        v0 = vld_count;
        drive(0, 5000);
        check("stuck0_flag", int'(stuck), 1);
        check("stuck0_lvl", int'(stuck_lvl), 0);
        check("stuck0_duty", int'(duty_out), 0);
        check("stuck0_period", int'(period_out), 0);
        check("stuck0_single_vld", vld_count - v0, 1);
        check("stuck0_latency", stuck_cyc - last_fall_cyc, 4098);

        gen(256, 3);
        check("resume_stuck", int'(stuck), 0);
        check("resume_duty", last_duty, 256);
        check("resume_period", last_period, 2048);

        repeat (4) begin
            drive(1, 3);
            drive(0, 5);
        end
        check("hand_duty", last_duty, 3);
        check("hand_period", last_period, 8);

        drive(1, 5000);
        check("stuck1_flag", int'(stuck), 1);
        check("stuck1_lvl", int'(stuck_lvl), 1);
        check("stuck1_duty", int'(duty_out), 2047);
        check("stuck1_period", int'(period_out), 0);

        drive(0, 20);
        drive(1, 10);
        #3 rst = 1'b1;
        #1;
        check("async_rst_duty", int'(duty_out), 0);
        check("async_rst_period", int'(period_out), 0);
        check("async_rst_stuck", int'(stuck), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = vld_count;
        drive(1, 10);
        drive(0, 20);
        check("post_rst_no_vld", vld_count - v0, 0);
        drive(1, 15);
        drive(0, 15);
        drive(1, 4);
        check("post_rst_vld_count", vld_count - v0, 2);
        check("post_rst_duty", last_duty, 15);
        check("post_rst_period", last_period, 30);

        drive(0, 20);
        for (int r = 0; r < 3; r++) begin
            h  = int'($urandom_range(5, 40));
            l  = int'($urandom_range(5, 40));
            p  = h + l;
            t0 = longint'($time);
            jit_reports = 0;
            for (int k = 0; k < 5; k++) begin
                wait_until(t0 + longint'(k * p * 10 + jit()));
                pwm_in = 1'b1;
                wait_until(t0 + longint'(k * p * 10 + h * 10 + jit()));
                pwm_in = 1'b0;
                if (k == 0) jit_nom = p;
            end
            wait_until(t0 + longint'(5 * p * 10 + jit()));
            pwm_in = 1'b1;
            repeat (4) @(negedge clk);
            jit_nom = 0;
            check("jitter_report_count", jit_reports, 5);
            drive(0, 20);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meas.md
Name: pwm_duty_meas

Overview:
Receive-side companion to the 11-bit PWM generator. Samples an asynchronous PWM input and measures high time and period in clk cycles. Publishes duty and period once per PWM period with a one-cycle valid strobe. Flags a stuck (0% / 100%) input after a timeout. Used for loopback self-test of motor/LED PWM paths and for reading external PWM sensors.

Parameters:
WIDTH, 11, duty counter width; nominal generator period = 2**WIDTH clks
SYNC_STAGES, 2, input synchronizer depth (>=2)
TIMEOUT, 4096, clks without any edge before the stuck flag asserts (must be > 2**WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pwm_in  input  1  asynchronous PWM signal under measurement
duty_out  output  WIDTH  high-time clk count of the last complete period
period_out  output  WIDTH+1  total clk count of the last complete period
meas_vld  output  1  one-cycle strobe: duty_out/period_out just updated
stuck  output  1  no edge for TIMEOUT clks; level held in stuck_lvl
stuck_lvl  output  1  synchronized pwm_in level while stuck=1

Behaviour:
- Reset (async, active-high): all outputs 0, synchronizer flops 0, counters 0, FSM = WAIT_RISE.
- Synchronizer: SYNC_STAGES flops feed s; one more flop gives s_d. rise = s & ~s_d, fall = ~s & s_d. Input-to-s latency = SYNC_STAGES clks, which is constant and does not affect measured widths.
- FSM states:
  - WAIT_RISE: counters held at 0. On rise: hi_cnt<=1, lo_cnt<=0, go to HIGH. The first partial period after reset is never reported.
  - HIGH: hi_cnt increments each clk while s=1. On fall: lo_cnt<=1, go to LOW.
  - LOW: lo_cnt increments each clk while s=0. On rise, registered in the next cycle:
    - duty_out<=hi_cnt, period_out<=hi_cnt+lo_cnt, meas_vld=1 for exactly 1 clk.
    - In the same rise cycle: hi_cnt<=1, lo_cnt<=0, go to HIGH (back-to-back periods, no gap).
- Widths: hi_cnt is WIDTH bits and saturates at all-ones. lo_cnt is WIDTH+1 bits and saturates. period_out sum saturates at all-ones of WIDTH+1. No wrap-around anywhere.
- Timeout: idle_cnt clears on any rise or fall and otherwise increments, saturating at TIMEOUT.
  - When idle_cnt reaches TIMEOUT: stuck<=1, stuck_lvl<=s, FSM -> WAIT_RISE.
    - If s=1: duty_out<=all-ones, period_out<=0.
    - If s=0: duty_out<=0, period_out<=0.
    - meas_vld pulses once on stuck entry.
  - stuck clears on the next rise or fall. Normal reporting resumes after a full period.
- Simultaneous timeout and edge in the same cycle: the edge wins; stuck does not assert.
- Single-clk glitches are measured as-is; there is no filtering.
- Reset mid-measurement: partial counts are discarded, outputs return to 0, and re-sync waits for a fresh rise.

Decomposition:
- Shared package pwm_pkg: WIDTH default constant, FSM state enum type (WAIT_RISE, HIGH, LOW), and the PWM_PERIOD = 2**WIDTH constant shared with the generator.
- Sub-module sync_edge_det: SYNC_STAGES synchronizer plus s_d flop; outputs s, rise, fall. Reusable by other async-input blocks.
- Counters, FSM, timeout and output registers stay in pwm_duty_meas.

Test Plan:
- Loopback from 11-bit generator, duty=0x200, hold 3 periods -> from the 2nd period onward, meas_vld pulses every 2048 clks with duty_out=0x200, period_out=2048, stuck=0.
- Generator duty=0x7FF -> duty_out=0x7FF, period_out=2048. Then duty=0x001 -> within 2 periods, duty_out=1, period_out=2048.
- Generator duty=0 (constant low), 5000 clks -> stuck=1 and stuck_lvl=0 at TIMEOUT clks after the last fall; duty_out=0, period_out=0, a single meas_vld. Restore duty=0x100 -> stuck clears at the first rise, and valid measurements resume.
- Hand-driven pwm_in: 3 clks high / 5 clks low, repeated -> duty_out=3, period_out=8. Hold high for 5000 clks -> stuck=1, stuck_lvl=1, duty_out=0x7FF.
- Assert rst mid-HIGH -> outputs 0 immediately (asynchronous). After deassert, no meas_vld before one complete rise-to-rise period has been observed.
- pwm_in driven asynchronously with random phase and jitter against clk -> every reported period_out is within ±1 of the driven period, and no X appears on any output.
